dpram_port_arbiter: RTL and testbench
=====================================

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 19, meaning the byte-address width.
REQ-002 SHALL have parameter ADDR_LINE, default 519168, meaning the memory depth in bytes.
REQ-003 SHALL have parameter INOUT_WIDTH, default 128, meaning the beat width (16 bytes).
REQ-004 SHALL have parameter NUM_REQ, default 3, meaning the number of requesters.
REQ-005 SHALL have parameter BURST_LEN, default 4, meaning the maximum number of locked beats.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk input 1, the rising-edge clock; rst_n input 1, the async active-low reset.
REQ-007 SHALL have req, input, NUM_REQ bits: per-requester access request.
REQ-008 SHALL have we, input, NUM_REQ bits: per-requester write (1) or read (0).
REQ-009 SHALL have addr, input, NUM_REQ*ADDR_WIDTH bits: flattened byte addresses, with requester i in slice i.
REQ-010 SHALL have wdata, input, NUM_REQ*INOUT_WIDTH bits: flattened write data.
REQ-011 SHALL have gnt, output, NUM_REQ bits: one-hot grant, asserted in the cycle the beat is issued.
REQ-012 SHALL have rvalid, output, NUM_REQ bits: one-hot read-data-valid.
REQ-013 SHALL have rdata, output, INOUT_WIDTH bits: read data shared by all requesters.
REQ-014 SHALL have mem_we, output, 1 bit, driving the memory port write enable.
REQ-015 SHALL have mem_addr, output, ADDR_WIDTH bits, driving the memory port address.
REQ-016 SHALL have mem_din, output, INOUT_WIDTH bits, driving the memory port write data.
REQ-017 SHALL have mem_dout, input, INOUT_WIDTH bits, the memory port read data, valid one cycle after a read is issued.
REQ-018 SHALL have err_oob, output, 1 bit: sticky out-of-range error flag.

Function
REQ-019 SHALL grant at most one requester per cycle, with gnt combinational from req, the round-robin pointer and the lock state.
REQ-020 SHALL perform round-robin arbitration: the search starts at requester (last_winner+1) mod NUM_REQ; after reset, last_winner = NUM_REQ-1, so requester 0 has first priority.
REQ-021 SHALL drive mem_we/mem_addr/mem_din combinationally from the granted requester's we/addr/wdata, and drive them to 0 when no grant is given.
REQ-022 SHALL treat a request as consumed in the cycle its gnt is high; a requester keeps req high with stable addr/we/wdata until it is granted.
REQ-023 SHALL register rvalid from (gnt & ~we) with exactly 1 cycle latency, and pass rdata through from mem_dout unregistered.
REQ-024 SHALL treat an address as out of range when addr > ADDR_LINE-16.
REQ-025 SHALL still grant an out-of-range request, but force mem_we=0, set err_oob sticky until reset, and for a read drive rdata=0 in its rvalid cycle.
REQ-026 SHALL update last_winner to the granted index on every grant, and leave it unchanged in a no-grant cycle.
REQ-027 SHALL accept back-to-back grants to different requesters every cycle, with no bubble.

Reset
REQ-028 SHALL, while rst_n=0, hold gnt, rvalid and mem_we at 0, hold err_oob at 0, set last_winner to NUM_REQ-1, clear the burst counter and set the lock state to ARB.
REQ-029 SHALL, when reset is asserted mid-burst or with a read in flight, drop the pending rvalid and release the lock immediately and asynchronously.

Configuration
REQ-030 SHALL, with ARB_BURST_LOCK_EN defined, implement states ARB and LOCK: a grant while other requests are pending enters LOCK.
REQ-031 SHALL, in LOCK, hold the grant on the same requester while its req stays high, for up to BURST_LEN total beats, using a counter of width clog2(BURST_LEN+1).
REQ-032 SHALL, in LOCK, return to ARB when req drops or the counter reaches BURST_LEN, and advance the round-robin pointer past the locked requester.
REQ-033 SHALL, without ARB_BURST_LOCK_EN, arbitrate every beat independently with pure round-robin, and contain no LOCK state or counter.

Structure
REQ-034 SHALL place the arbiter state enumeration (ARB, LOCK) and the beat-bytes constant (16) in the shared package dpram_pkg.
REQ-035 SHALL implement the rotate-and-priority-encode function in one sub-module, rr_pick (inputs: NUM_REQ-bit request vector and pointer; output: one-hot pick).

Verification
REQ-036 SHALL cover: req=3'b111 held, macro off -> gnt sequence 001, 010, 100, 001 on consecutive cycles.
REQ-037 SHALL cover: req0 read at addr 0x40 -> mem_addr=0x40, mem_we=0 in cycle t, then rvalid=001 in t+1 with rdata=mem_dout.
REQ-038 SHALL cover: req1 write at addr 519153 -> gnt=010, mem_we=0, err_oob=1 from t+1 until rst_n low.
REQ-039 SHALL cover: macro on, BURST_LEN=4, req=3'b011 held -> gnt 001 x4, then 010 x4, then 001.
REQ-040 SHALL cover: macro on, rst_n pulsed low during beat 2 of a burst -> gnt, rvalid and err_oob read 0, and the first grant after release goes to requester 0.
REQ-041 SHALL cover: req=0 for 5 cycles -> no gnt, mem_we=0, pointer unchanged; then req=3'b100 -> gnt=100 in the same cycle.

Source files
------------

// File: rtl/dpram_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg -- shared definitions for the DPRAM port arbiter.
//   arb_state_t : arbiter lock state (ARB = free arbitration, LOCK = burst hold)
//   BEAT_BYTES  : bytes moved per memory beat
// ---------------------------------------------------------------------------
package dpram_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int BEAT_BYTES = 16;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- rotate-and-priority-encode for round-robin arbitration.
//   req  : NUM_REQ-bit request vector
//   ptr  : index where the search starts (highest priority)
//   pick : one-hot winner, all zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  logic [PTR_W-1:0] idx;

  // Walk from the farthest offset back to ptr so the last hit, i.e. the one
  // closest to ptr, is the one that survives.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter -- shares one memory port between NUM_REQ requesters.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   req/we/addr/wdata : per-requester request, write flag, byte address, data
//                       (addr/wdata flattened, requester i in slice i)
//   gnt               : one-hot grant, combinational, high in the issue cycle
//   rvalid            : one-hot read-data-valid, one cycle after a read grant
//   rdata             : shared read data (mem_dout passed through)
//   mem_we/addr/din   : memory port drive, zero when nothing is granted
//   mem_dout          : memory read data, valid one cycle after the read
//   err_oob           : sticky flag, set by any out-of-range grant
//   dbg_state         : arbiter lock state (always ARB without burst lock)
//
// Handshake: a requester raises req with stable we/addr/wdata and holds them
// until it sees gnt; the beat is issued and the request consumed in the
// cycle gnt is high. There is no back-pressure after the grant.
//
// Build option: define ARB_BURST_LOCK_EN to let a winner keep the port for
// up to BURST_LEN consecutive beats while others are waiting.
// ---------------------------------------------------------------------------
module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 19,
  parameter int ADDR_LINE   = 519168,
  parameter int INOUT_WIDTH = 128,
  parameter int NUM_REQ     = 3,
  parameter int BURST_LEN   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_REQ*INOUT_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [INOUT_WIDTH-1:0]         rdata,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [INOUT_WIDTH-1:0]         mem_din,
  input  logic [INOUT_WIDTH-1:0]         mem_dout,
  output logic                           err_oob,
  output arb_state_t                     dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  // Highest start address whose full beat still fits in the memory.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(ADDR_LINE - BEAT_BYTES);

  logic [PTR_W-1:0]       last_winner;
  logic [PTR_W-1:0]       start_ptr;
  logic [PTR_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]     pick;
  logic [NUM_REQ-1:0]     gnt_int;
  logic                   we_g;
  logic [ADDR_WIDTH-1:0]  addr_g;
  logic [INOUT_WIDTH-1:0] wdata_g;
  logic                   oob;
  logic [NUM_REQ-1:0]     rvalid_q;
  logic                   rd_oob_q;
  logic                   err_q;

  assign start_ptr = (last_winner == LAST_IDX) ? '0 : last_winner + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req  (req),
    .ptr  (start_ptr),
    .pick (pick)
  );

`ifdef ARB_BURST_LOCK_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

  arb_state_t       state;
  logic [CNT_W-1:0] beat_cnt;     // beats already given in the current burst
  logic             lock_active;

  // last_winner is the locked requester while in LOCK, so no separate index.
  assign lock_active = (state == LOCK) && req[last_winner];

  always_comb begin
    gnt_int = pick;
    if (lock_active) begin
      gnt_int              = '0;
      gnt_int[last_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      beat_cnt <= '0;
    end else if (lock_active) begin
      if (beat_cnt + 1'b1 >= CNT_MAX) begin
        state    <= ARB;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end else if ((|pick) && (|(req & ~pick)) && (BURST_LEN > 1)) begin
      // Fresh winner with others waiting: this grant is beat 1 of a burst.
      state    <= LOCK;
      beat_cnt <= CNT_W'(1);
    end else begin
      state    <= ARB;
      beat_cnt <= '0;
    end
  end

  assign dbg_state = state;
`else
  assign gnt_int   = pick;
  assign dbg_state = ARB;
`endif

  // Reset blanks the grant immediately, without waiting for a clock.
  assign gnt = rst_n ? gnt_int : '0;

  always_comb begin
    we_g    = 1'b0;
    addr_g  = '0;
    wdata_g = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        we_g    = we[i];
        addr_g  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_g = wdata[i*INOUT_WIDTH +: INOUT_WIDTH];
        gnt_idx = PTR_W'(i);
      end
    end
  end

  // Out-of-range beats are still granted so the requester is not stuck,
  // but they never write and read back as zero.
  assign oob      = (|gnt) && (addr_g > ADDR_MAX);
  assign mem_we   = we_g & ~oob;
  assign mem_addr = addr_g;
  assign mem_din  = wdata_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= LAST_IDX;
      rvalid_q    <= '0;
      rd_oob_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (|gnt) begin
        last_winner <= gnt_idx;
      end
      rvalid_q <= gnt & ~we;
      rd_oob_q <= oob & ~we_g;
      err_q    <= err_q | oob;
    end
  end

  assign rvalid  = rvalid_q;
  assign rdata   = rd_oob_q ? '0 : mem_dout;
  assign err_oob = err_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;
  import dpram_pkg::*;

  localparam int AW = 19;
  localparam int IW = 128;
  localparam int N  = 3;
  localparam logic [AW-1:0] EDGE_A = AW'(519152);
  localparam logic [AW-1:0] A0 = AW'('h200);
  localparam logic [AW-1:0] A1 = AW'('h300);
  localparam logic [AW-1:0] A2 = AW'('h400);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*IW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [IW-1:0]   rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [IW-1:0]   mem_din;
  logic [IW-1:0]   mem_dout;
  logic            err_oob;
  arb_state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q[$];
  logic [N-1:0]  exp_rv;
  logic [IW-1:0] exp_d;
  logic [IW-1:0] ref_mem  [logic [AW-1:0]];
  logic [IW-1:0] mem_model[logic [AW-1:0]];

  dpram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .err_oob(err_oob), .dbg_state(dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] pat(input logic [AW-1:0] a);
    return {4{32'hA5A5_0000 ^ {13'h0, a}}};
  endfunction

  function automatic logic [IW-1:0] exp_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] = mem_din;
    mem_dout <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : pat(mem_addr);
  end

  // ---------------- drivers ----------------
  task automatic clear_req();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [IW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*IW +: IW] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(32 * i), IW'(i + 1));
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL reset_rvalid got %b want 000", rvalid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_oob); end
    checks++; if (dbg_state !== ARB) begin errors++; $display("FAIL reset_state got %0d want ARB", dbg_state); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_req();
    exp_rv = '0;
    exp_q.delete();
  endtask

`ifndef ARB_BURST_LOCK_EN
  task automatic test_round_robin();
    logic [N-1:0] eg;
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(256 * (i + 1)), '0);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) clear_req();
      eg = (c < 4) ? N'(1) << (c % N) : '0;
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt c%0d got %b want %b", c, gnt, eg); end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL rr_rvalid c%0d got %b want %b", c, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        exp_d = exp_q.pop_front();
        checks++; if (rdata !== exp_d) begin errors++; $display("FAIL rr_rdata c%0d got %h want %h", c, rdata, exp_d); end
      end
      exp_rv = eg;
      if (c < 4) exp_q.push_back(exp_rd(AW'(256 * ((c % N) + 1))));
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_burst();
    logic [N-1:0] eg;
    clear_req();
    set_req(0, 1'b0, A0, '0);
    set_req(1, 1'b0, A1, '0);
    for (int c = 0; c < 10; c++) begin
      if (c == 9) clear_req();
      eg = (c < 4) ? 3'b001 : (c < 8) ? 3'b010 : (c == 8) ? 3'b001 : 3'b000;
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL burst_gnt c%0d got %b want %b", c, gnt, eg); end
      if (c == 2) begin
        checks++; if (dbg_state !== LOCK) begin errors++; $display("FAIL burst_state c%0d got %0d want LOCK", c, dbg_state); end
      end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL burst_rvalid c%0d got %b want %b", c, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        exp_d = exp_q.pop_front();
        checks++; if (rdata !== exp_d) begin errors++; $display("FAIL burst_rdata c%0d got %h want %h", c, rdata, exp_d); end
      end
      exp_rv = eg;
      if (eg != '0) exp_q.push_back(exp_rd(eg[0] ? A0 : A1));
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_write_read();
    logic [IW-1:0] d;
    logic [N-1:0]  eg;
    logic          ew;
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      clear_req();
      case (c)
        0:       begin set_req(2, 1'b1, AW'('h40), d);  eg = 3'b100; ew = 1'b1; end
        1:       begin set_req(0, 1'b0, AW'('h40), '0); eg = 3'b001; ew = 1'b0; end
        default: begin eg = '0; ew = 1'b0; end
      endcase
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL wr_gnt c%0d got %b want %b", c, gnt, eg); end
      checks++; if (mem_we !== ew) begin errors++; $display("FAIL wr_mem_we c%0d got %b want %b", c, mem_we, ew); end
      if (c < 2) begin
        checks++; if (mem_addr !== AW'('h40)) begin errors++; $display("FAIL wr_mem_addr c%0d got %h want 40", c, mem_addr); end
      end
      if (c == 0) begin
        checks++; if (mem_din !== d) begin errors++; $display("FAIL wr_mem_din got %h want %h", mem_din, d); end
      end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL wr_rvalid c%0d got %b want %b", c, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        exp_d = exp_q.pop_front();
        checks++; if (rdata !== exp_d) begin errors++; $display("FAIL wr_rdata c%0d got %h want %h", c, rdata, exp_d); end
      end
      exp_rv = eg & ~we;
      if (c == 0) ref_mem[AW'('h40)] = d;
      if (c == 1) exp_q.push_back(exp_rd(AW'('h40)));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_idle();
    logic [N-1:0] eg;
    for (int c = 0; c < 8; c++) begin
      clear_req();
      if (c == 5) begin
        set_req(1, 1'b0, A1, '0);
        set_req(2, 1'b0, A2, '0);
        eg = 3'b010;
      end else if (c == 6) begin
        set_req(2, 1'b0, A2, '0);
        eg = 3'b100;
      end else begin
        eg = '0;
      end
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL idle_gnt c%0d got %b want %b", c, gnt, eg); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_mem_we c%0d got %b want 0", c, mem_we); end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL idle_rvalid c%0d got %b want %b", c, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        exp_d = exp_q.pop_front();
        checks++; if (rdata !== exp_d) begin errors++; $display("FAIL idle_rdata c%0d got %h want %h", c, rdata, exp_d); end
      end
      exp_rv = eg;
      if (eg != '0) exp_q.push_back(exp_rd(eg[1] ? A1 : A2));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_oob();
    logic [IW-1:0] d1, d2;
    logic [N-1:0]  eg;
    logic          ew, ee;
    d1 = {4{$urandom}};
    d2 = {4{$urandom}};
    for (int c = 0; c < 7; c++) begin
      clear_req();
      case (c)
        0:       begin set_req(0, 1'b1, EDGE_A, d1);          eg = 3'b001; ew = 1'b1; ee = 1'b0; end
        1:       begin set_req(1, 1'b1, AW'(519153), d2);     eg = 3'b010; ew = 1'b0; ee = 1'b0; end
        2:       begin set_req(2, 1'b0, AW'(519160), '0);     eg = 3'b100; ew = 1'b0; ee = 1'b1; end
        3:       begin set_req(0, 1'b0, EDGE_A, '0);          eg = 3'b001; ew = 1'b0; ee = 1'b1; end
        default: begin eg = '0; ew = 1'b0; ee = 1'b1; end
      endcase
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL oob_gnt c%0d got %b want %b", c, gnt, eg); end
      checks++; if (mem_we !== ew) begin errors++; $display("FAIL oob_mem_we c%0d got %b want %b", c, mem_we, ew); end
      checks++; if (err_oob !== ee) begin errors++; $display("FAIL oob_err c%0d got %b want %b", c, err_oob, ee); end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL oob_rvalid c%0d got %b want %b", c, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        exp_d = exp_q.pop_front();
        checks++; if (rdata !== exp_d) begin errors++; $display("FAIL oob_rdata c%0d got %h want %h", c, rdata, exp_d); end
      end
      exp_rv = eg & ~we;
      if (c == 0) ref_mem[EDGE_A] = d1;
      if (c == 2) exp_q.push_back('0);
      if (c == 3) exp_q.push_back(exp_rd(EDGE_A));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int            ri, prev;
    logic          w;
    logic [AW-1:0] a;
    logic [IW-1:0] d;
    logic [N-1:0]  eg;
    prev = 0;
    a = '0;
    d = '0;
    for (int c = 0; c < 13; c++) begin
      clear_req();
      if (c < 12) begin
        ri   = (prev + 1 + int'($urandom_range(0, 1))) % N;
        prev = ri;
        w    = 1'($urandom_range(0, 1));
        a    = AW'($urandom_range(0, 32447) * 16);
        d    = {$urandom, $urandom, $urandom, $urandom};
        set_req(ri, w, a, d);
        eg   = N'(1) << ri;
      end else begin
        w  = 1'b0;
        eg = '0;
      end
      @(negedge clk);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL b2b_gnt c%0d got %b want %b", c, gnt, eg); end
      checks++; if (mem_we !== w) begin errors++; $display("FAIL b2b_mem_we c%0d got %b want %b", c, mem_we, w); end
      if (c < 12) begin
        checks++; if (mem_addr !== a) begin errors++; $display("FAIL b2b_mem_addr c%0d got %h want %h", c, mem_addr, a); end
      end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL b2b_rvalid c%0d got %b want %b", c, rvalid, exp_rv); end
      if (exp_rv != '0) begin
        exp_d = exp_q.pop_front();
        checks++; if (rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata c%0d got %h want %h", c, rdata, exp_d); end
      end
      exp_rv = w ? '0 : eg;
      if (c < 12) begin
        if (w) ref_mem[a] = d;
        else   exp_q.push_back(exp_rd(a));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] eg2;
`ifdef ARB_BURST_LOCK_EN
    eg2 = 3'b010;
`else
    eg2 = 3'b001;
`endif
    clear_req();
    set_req(0, 1'b0, A0, '0);
    @(negedge clk);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL mid_gnt0 got %b want 001", gnt); end
    exp_rv = 3'b001;
    exp_q.push_back(exp_rd(A0));
    @(posedge clk); #1;
    set_req(1, 1'b0, A1, '0);
    @(negedge clk);
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL mid_gnt1 got %b want 010", gnt); end
    checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL mid_rvalid1 got %b want %b", rvalid, exp_rv); end
    exp_d = exp_q.pop_front();
    checks++; if (rdata !== exp_d) begin errors++; $display("FAIL mid_rdata1 got %h want %h", rdata, exp_d); end
    exp_rv = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (gnt !== eg2) begin errors++; $display("FAIL mid_gnt2 got %b want %b", gnt, eg2); end
    checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL mid_rvalid2 got %b want %b", rvalid, exp_rv); end
    // Pull reset while beat 2 is on the port and its read is about to launch.
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL mid_rst_gnt got %b want 000", gnt); end
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL mid_rst_rvalid got %b want 000", rvalid); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", err_oob); end
    checks++; if (dbg_state !== ARB) begin errors++; $display("FAIL mid_rst_state got %0d want ARB", dbg_state); end
    exp_q.delete();
    exp_rv = '0;
    @(posedge clk); #1;
    clear_req();
    set_req(0, 1'b0, A0, '0);
    set_req(1, 1'b0, A1, '0);
    set_req(2, 1'b0, A2, '0);
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL mid_hold_gnt got %b want 000", gnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL mid_first_gnt got %b want 001", gnt); end
    exp_rv = 3'b001;
    exp_q.push_back(exp_rd(A0));
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL mid_post_rvalid got %b want %b", rvalid, exp_rv); end
    exp_d = exp_q.pop_front();
    checks++; if (rdata !== exp_d) begin errors++; $display("FAIL mid_post_rdata got %h want %h", rdata, exp_d); end
    exp_rv = '0;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_req();
    exp_rv = '0;
    test_reset();
`ifdef ARB_BURST_LOCK_EN
    test_burst();
`else
    test_round_robin();
`endif
    test_write_read();
    test_idle();
    test_oob();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
